// File: rtl/oddr_serializer.sv
// Parallel-to-DDR output serializer: buffers one word behind the shifter and
// emits two bits per clock on Q (first bit while C is high, second while C is low).
module oddr_serializer #(
   parameter int   DATA_WIDTH = 8,
   parameter int   MSB_FIRST  = 1,
   parameter logic INIT_Q     = 1'b0,
   parameter logic IDLE_Q     = 1'b0
) (
   input  logic                  C,
   input  logic                  R,
   input  logic                  CE,
   input  logic [DATA_WIDTH-1:0] TDATA,
   input  logic                  TVALID,
   output logic                  TREADY,
   output logic                  Q,
   output logic                  BUSY,
   output logic                  UNDERRUN
);

   localparam int N     = DATA_WIDTH / 2;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   localparam logic [1:0] ACT_HOLD  = 2'd0;
   localparam logic [1:0] ACT_SHIFT = 2'd1;
   localparam logic [1:0] ACT_LOAD  = 2'd2;
   localparam logic [1:0] ACT_IDLE  = 2'd3;

   // The pair that leaves next always sits at the head of the word.
   function automatic logic [1:0] head_pair(input logic [DATA_WIDTH-1:0] w);
      if (MSB_FIRST != 0) begin
         head_pair = w[DATA_WIDTH-1 -: 2];
      end else begin
         head_pair = {w[0], w[1]};
      end
   endfunction

   function automatic logic [DATA_WIDTH-1:0] drop_pair(input logic [DATA_WIDTH-1:0] w);
      if (MSB_FIRST != 0) begin
         drop_pair = w << 2;
      end else begin
         drop_pair = w >> 2;
      end
   endfunction

   logic [DATA_WIDTH-1:0] buf_r;
   logic                  buf_v_r;
   logic [DATA_WIDTH-1:0] sh_r;
   logic [CNT_W-1:0]      cnt_r;
   logic                  sending_r;
   logic                  p1_r;
   logic                  p2_r;
   logic                  underrun_r;

   logic       last_s;
   logic       load_now_s;
   logic       tready_s;
   logic       accept_s;
   logic [1:0] action_s;

   assign last_s     = (cnt_r == CNT_LAST);
   assign load_now_s = CE & buf_v_r & (~sending_r | last_s);
   assign tready_s   = ~R & CE & (~buf_v_r | load_now_s);
   assign accept_s   = TVALID & tready_s;

   // Select the single action taken at the next enabled posedge.
   always_comb begin
      if (!CE) begin
         action_s = ACT_HOLD;
      end else if (sending_r && !last_s) begin
         action_s = ACT_SHIFT;
      end else if (buf_v_r) begin
         action_s = ACT_LOAD;
      end else begin
         action_s = ACT_IDLE;
      end
   end

   // Holding buffer; may be refilled on the same edge it drains into the shifter.
   always_ff @(posedge C) begin
      if (R) begin
         buf_r   <= '0;
         buf_v_r <= 1'b0;
      end else if (accept_s) begin
         buf_r   <= TDATA;
         buf_v_r <= 1'b1;
      end else if (load_now_s) begin
         buf_v_r <= 1'b0;
      end else begin
         buf_v_r <= buf_v_r;
      end
   end

   // Shifter, pair register and underrun pulse.
   always_ff @(posedge C) begin
      if (R) begin
         sh_r       <= '0;
         cnt_r      <= '0;
         sending_r  <= 1'b0;
         p1_r       <= INIT_Q;
         p2_r       <= INIT_Q;
         underrun_r <= 1'b0;
      end else begin
         underrun_r <= 1'b0;
         case (action_s)
            ACT_SHIFT: begin
               {p1_r, p2_r} <= head_pair(sh_r);
               sh_r         <= drop_pair(sh_r);
               cnt_r        <= cnt_r + CNT_W'(1);
            end
            ACT_LOAD: begin
               {p1_r, p2_r} <= head_pair(buf_r);
               sh_r         <= drop_pair(buf_r);
               cnt_r        <= '0;
               sending_r    <= 1'b1;
            end
            ACT_IDLE: begin
               p1_r       <= IDLE_Q;
               p2_r       <= IDLE_Q;
               sending_r  <= 1'b0;
               underrun_r <= sending_r;
            end
            default: begin
               sending_r <= sending_r;
            end
         endcase
      end
   end

   assign TREADY   = tready_s;
   assign BUSY     = sending_r | buf_v_r;
   assign UNDERRUN = underrun_r;
   // Phase mux: the pair only changes at posedge, so the high phase always shows p1 first.
   assign Q        = C ? p1_r : p2_r;

endmodule
